// File: rtl/ghr_checkpoint_queue_if.sv
// Handshake bundle between fetch/branch-unit/commit logic and the GHR
// checkpoint queue. The master side is the pipeline; the slave side is the queue.
interface ghr_checkpoint_queue_if #(
    parameter int GHR_SIZE = 9,
    parameter int DEPTH    = 16
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                alloc_valid;
    logic [GHR_SIZE-1:0] alloc_ghr;
    logic                alloc_ready;
    logic [TAG_W-1:0]    alloc_tag;

    logic                resolve_valid;
    logic [TAG_W-1:0]    resolve_tag;
    logic                resolve_mispred;
    logic                resolve_taken;

    logic                commit_valid;

    logic                restore_ghr;
    logic [GHR_SIZE-1:0] ghr_snap;
    logic                actual_taken;
    logic                empty;
    logic                full;

    modport master (
        output alloc_valid, alloc_ghr,
        output resolve_valid, resolve_tag, resolve_mispred, resolve_taken,
        output commit_valid,
        input  alloc_ready, alloc_tag,
        input  restore_ghr, ghr_snap, actual_taken,
        input  empty, full
    );

    modport slave (
        input  alloc_valid, alloc_ghr,
        input  resolve_valid, resolve_tag, resolve_mispred, resolve_taken,
        input  commit_valid,
        output alloc_ready, alloc_tag,
        output restore_ghr, ghr_snap, actual_taken,
        output empty, full
    );
endinterface

// File: rtl/ghr_checkpoint_queue.sv
// Circular queue of global-history checkpoints, one entry per in-flight
// predicted branch. Allocated at predict, restored from on mispredict
// (younger entries squashed), freed in program order at commit.
// Optional build macro: GHRQ_STATS_EN adds saturating mispredict/resolve counters.
module ghr_checkpoint_queue #(
    parameter int GHR_SIZE = 9,
    parameter int DEPTH    = 16
) (
    input  logic CLK,
    input  logic reset,
    ghr_checkpoint_queue_if.slave q
`ifdef GHRQ_STATS_EN
    ,
    output logic [31:0] mispred_count,
    output logic [31:0] resolve_count
`endif
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int PTR_W = TAG_W + 1;

    logic [GHR_SIZE-1:0] snap [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [DEPTH-1:0]    valid_nxt;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W-1:0]    head_nxt;
    logic [PTR_W-1:0]    tail_nxt;
    logic [PTR_W-1:0]    tail_mis;

    logic                restore_q;
    logic [GHR_SIZE-1:0] ghr_snap_q;
    logic                actual_taken_q;

    logic                empty_w;
    logic                full_w;
    logic                alloc_ready_w;
    logic                res_hit;
    logic                mis_hit;
    logic                alloc_fire;
    logic                commit_fire;
    logic                mis_wrap;
    logic [TAG_W-1:0]    mis_off;
    logic [TAG_W-1:0]    ent_off;
    logic [DEPTH-1:0]    squash;

    assign empty_w       = (head == tail);
    assign full_w        = (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);
    // Fetch stalls while the GHR is being rebuilt so no allocation sees a stale history.
    assign alloc_ready_w = !full_w && !restore_q;

    assign res_hit     = q.resolve_valid && valid[q.resolve_tag];
    assign mis_hit     = res_hit && q.resolve_mispred;
    assign alloc_fire  = q.alloc_valid && alloc_ready_w && !mis_hit;
    assign commit_fire = q.commit_valid && !empty_w;

    // The mispredicted entry stays in the queue; its wrap bit is the head's
    // unless its index sits below the head index, i.e. it lives past the wrap.
    assign mis_wrap = (q.resolve_tag >= head[TAG_W-1:0]) ? head[TAG_W] : ~head[TAG_W];
    assign tail_mis = {mis_wrap, q.resolve_tag} + PTR_W'(1);
    assign mis_off  = q.resolve_tag - head[TAG_W-1:0];

    // Entries further from the head than the mispredicted one are younger.
    always_comb begin
        squash  = '0;
        ent_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_off   = TAG_W'(i) - head[TAG_W-1:0];
            squash[i] = (ent_off > mis_off);
        end
    end

    // Next-state of valid bits and pointers; mispredict overrides a same-cycle alloc.
    always_comb begin
        valid_nxt = valid;
        head_nxt  = head;
        tail_nxt  = tail;
        if (commit_fire) begin
            valid_nxt[head[TAG_W-1:0]] = 1'b0;
            head_nxt = head + PTR_W'(1);
        end
        if (mis_hit) begin
            valid_nxt = valid_nxt & ~squash;
            tail_nxt  = tail_mis;
        end else if (alloc_fire) begin
            valid_nxt[tail[TAG_W-1:0]] = 1'b1;
            tail_nxt = tail + PTR_W'(1);
        end
    end

    // Pointer, valid and restore-pulse registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            valid          <= '0;
            restore_q      <= 1'b0;
            ghr_snap_q     <= '0;
            actual_taken_q <= 1'b0;
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            valid     <= valid_nxt;
            restore_q <= mis_hit;
            if (mis_hit) begin
                ghr_snap_q     <= snap[q.resolve_tag];
                actual_taken_q <= q.resolve_taken;
            end
        end
    end

    // Snapshot storage; contents are only meaningful where valid is set.
    always_ff @(posedge CLK) begin
        if (alloc_fire) begin
            snap[tail[TAG_W-1:0]] <= q.alloc_ghr;
        end
    end

`ifdef GHRQ_STATS_EN
    // Saturating event counters for performance monitoring.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mispred_count <= '0;
            resolve_count <= '0;
        end else begin
            if (mis_hit && (mispred_count != 32'hFFFF_FFFF)) begin
                mispred_count <= mispred_count + 32'd1;
            end
            if (res_hit && (resolve_count != 32'hFFFF_FFFF)) begin
                resolve_count <= resolve_count + 32'd1;
            end
        end
    end
`endif

    assign q.alloc_ready  = alloc_ready_w;
    assign q.alloc_tag    = tail[TAG_W-1:0];
    assign q.restore_ghr  = restore_q;
    assign q.ghr_snap     = ghr_snap_q;
    assign q.actual_taken = actual_taken_q;
    assign q.empty        = empty_w;
    assign q.full         = full_w;
endmodule

// File: tb/tb_ghr_checkpoint_queue.sv
// Directed bench for ghr_checkpoint_queue: allocation/commit, fill and
// overflow, mispredict restore and squash, tail wrap, reset during restore.
module tb_ghr_checkpoint_queue;
    logic CLK;
    logic reset;
    int   total;
    int   bad;

    ghr_checkpoint_queue_if #(.GHR_SIZE(9), .DEPTH(16)) bus ();

`ifdef GHRQ_STATS_EN
    logic [31:0] mispred_count;
    logic [31:0] resolve_count;
`endif

    ghr_checkpoint_queue #(.GHR_SIZE(9), .DEPTH(16)) dut (
        .CLK   (CLK),
        .reset (reset),
        .q     (bus.slave)
`ifdef GHRQ_STATS_EN
        ,
        .mispred_count (mispred_count),
        .resolve_count (resolve_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_ghr       = '0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_tag     = '0;
        bus.resolve_mispred = 1'b0;
        bus.resolve_taken   = 1'b0;
        bus.commit_valid    = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_alloc(input logic [8:0] g);
        bus.alloc_valid = 1'b1;
        bus.alloc_ghr   = g;
        tick();
        idle();
    endtask

    task automatic do_commit();
        bus.commit_valid = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_resolve(input logic [3:0] t, input logic mis, input logic tk);
        bus.resolve_valid   = 1'b1;
        bus.resolve_tag     = t;
        bus.resolve_mispred = mis;
        bus.resolve_taken   = tk;
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_full",   32'(bus.full), 32'd0);
        chk("rst_ready",  32'(bus.alloc_ready), 32'd1);
        chk("rst_tag",    32'(bus.alloc_tag), 32'd0);
        chk("rst_restore",32'(bus.restore_ghr), 32'd0);
        chk("rst_snap",   32'(bus.ghr_snap), 32'd0);
        chk("rst_taken",  32'(bus.actual_taken), 32'd0);
        reset = 1'b1;
        tick();

        // 1: three allocs then three commits
        chk("t1_tag0", 32'(bus.alloc_tag), 32'd0);
        do_alloc(9'h001);
        chk("t1_tag1", 32'(bus.alloc_tag), 32'd1);
        do_alloc(9'h002);
        chk("t1_tag2", 32'(bus.alloc_tag), 32'd2);
        do_alloc(9'h004);
        chk("t1_notempty", 32'(bus.empty), 32'd0);
        do_commit();
        do_commit();
        chk("t1_one_left", 32'(bus.empty), 32'd0);
        do_commit();
        chk("t1_empty", 32'(bus.empty), 32'd1);
        chk("t1_tail3", 32'(bus.alloc_tag), 32'd3);

        // 2: fill from head=tail=3
        for (int i = 0; i < 16; i++) begin
            chk("t2_filltag", 32'(bus.alloc_tag), 32'((3 + i) % 16));
            do_alloc(9'(i));
        end
        chk("t2_full",  32'(bus.full), 32'd1);
        chk("t2_ready", 32'(bus.alloc_ready), 32'd0);
        do_alloc(9'h1FF);
        chk("t2_drop_full", 32'(bus.full), 32'd1);
        chk("t2_drop_tag",  32'(bus.alloc_tag), 32'd3);
        bus.alloc_valid  = 1'b1;
        bus.alloc_ghr    = 9'h1EE;
        bus.commit_valid = 1'b1;
        tick();
        idle();
        chk("t2_commit_full",  32'(bus.full), 32'd0);
        chk("t2_commit_ready", 32'(bus.alloc_ready), 32'd1);
        chk("t2_commit_tag",   32'(bus.alloc_tag), 32'd3);
        for (int i = 0; i < 15; i++) do_commit();
        chk("t2_drained", 32'(bus.empty), 32'd1);

        // 3: tags 0..5 then mispredict tag 2
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) do_alloc(9'(9'h010 + i));
        chk("t3_tag6", 32'(bus.alloc_tag), 32'd6);
        do_resolve(4'd2, 1'b1, 1'b1);
        chk("t3_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t3_snap",    32'(bus.ghr_snap), 32'h012);
        chk("t3_taken",   32'(bus.actual_taken), 32'd1);
        chk("t3_ready0",  32'(bus.alloc_ready), 32'd0);
        chk("t3_tag3",    32'(bus.alloc_tag), 32'd3);
        tick();
        chk("t3_pulse_end", 32'(bus.restore_ghr), 32'd0);
        chk("t3_ready1",    32'(bus.alloc_ready), 32'd1);
        chk("t3_snap_hold", 32'(bus.ghr_snap), 32'h012);
        do_resolve(4'd1, 1'b0, 1'b0);
        chk("t3_correct_norestore", 32'(bus.restore_ghr), 32'd0);
        chk("t3_correct_tag",       32'(bus.alloc_tag), 32'd3);
        do_resolve(4'd5, 1'b1, 1'b1);
        chk("t3_squashed_norestore", 32'(bus.restore_ghr), 32'd0);

        // 4: mispredict tag 1 with a same-cycle alloc
        bus.alloc_valid     = 1'b1;
        bus.alloc_ghr       = 9'h1AA;
        bus.resolve_valid   = 1'b1;
        bus.resolve_tag     = 4'd1;
        bus.resolve_mispred = 1'b1;
        bus.resolve_taken   = 1'b0;
        tick();
        idle();
        chk("t4_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t4_snap",    32'(bus.ghr_snap), 32'h011);
        chk("t4_taken",   32'(bus.actual_taken), 32'd0);
        chk("t4_tag2",    32'(bus.alloc_tag), 32'd2);
        tick();
        do_commit();
        chk("t4_one_left", 32'(bus.empty), 32'd0);
        do_commit();
        chk("t4_empty", 32'(bus.empty), 32'd1);
        do_resolve(4'd0, 1'b1, 1'b1);
        chk("t4_freed_norestore", 32'(bus.restore_ghr), 32'd0);
        chk("t4_freed_empty",     32'(bus.empty), 32'd1);

        // commit + mispredict on the head tag
        do_alloc(9'h0A0);
        do_alloc(9'h0A1);
        bus.commit_valid    = 1'b1;
        bus.resolve_valid   = 1'b1;
        bus.resolve_tag     = 4'd2;
        bus.resolve_mispred = 1'b1;
        bus.resolve_taken   = 1'b1;
        tick();
        idle();
        chk("t4h_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t4h_snap",    32'(bus.ghr_snap), 32'h0A0);
        chk("t4h_empty",   32'(bus.empty), 32'd1);
        chk("t4h_tag",     32'(bus.alloc_tag), 32'd3);
        tick();

        // 5: tail wrap, head=tail=3
        for (int i = 0; i < 20; i++) begin
            chk("t5_wraptag", 32'(bus.alloc_tag), 32'((3 + i) % 16));
            bus.commit_valid = (i >= 4);
            do_alloc(9'(9'h100 + i));
        end
        chk("t5_tag7", 32'(bus.alloc_tag), 32'd7);
        do_resolve(4'd5, 1'b1, 1'b0);
        chk("t5_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t5_snap",    32'(bus.ghr_snap), 32'h112);
        chk("t5_tag6",    32'(bus.alloc_tag), 32'd6);
        tick();
        do_commit();
        do_commit();
        for (int i = 0; i < 12; i++) do_alloc(9'(9'h150 + i));
        chk("t5_tag2", 32'(bus.alloc_tag), 32'd2);
        do_resolve(4'd0, 1'b1, 1'b1);
        chk("t5w_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t5w_snap",    32'(bus.ghr_snap), 32'h15A);
        chk("t5w_tag1",    32'(bus.alloc_tag), 32'd1);
        chk("t5w_notfull", 32'(bus.full), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) do_alloc(9'(9'h160 + i));
        chk("t5w_full",  32'(bus.full), 32'd1);
        chk("t5w_empty", 32'(bus.empty), 32'd0);

        // 6: reset asserted during the restore pulse
        do_resolve(4'd9, 1'b1, 1'b1);
        chk("t6_restore", 32'(bus.restore_ghr), 32'd1);
        chk("t6_snap",    32'(bus.ghr_snap), 32'h153);
`ifdef GHRQ_STATS_EN
        chk("t6_mispred_cnt", mispred_count, 32'd6);
        chk("t6_resolve_cnt", resolve_count, 32'd7);
`endif
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_restore", 32'(bus.restore_ghr), 32'd0);
        chk("t6_rst_empty",   32'(bus.empty), 32'd1);
        chk("t6_rst_full",    32'(bus.full), 32'd0);
        chk("t6_rst_tag",     32'(bus.alloc_tag), 32'd0);
`ifdef GHRQ_STATS_EN
        chk("t6_rst_mispred_cnt", mispred_count, 32'd0);
        chk("t6_rst_resolve_cnt", resolve_count, 32'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        chk("t6_post_empty", 32'(bus.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
